// File: rtl/dcache_ctrl.sv
// Direct-mapped write-back/write-allocate data cache controller with a line-wide refill port.
// Optional hit/miss statistics are built only when DCACHE_STATS_EN is defined.
module dcache_ctrl #(
  parameter int INDEX_W = 5
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [31:0]  p1_addr_i,
  input  logic [31:0]  p1_data_i,
  input  logic         p1_MemRead_i,
  input  logic         p1_MemWrite_i,
  output logic [31:0]  p1_data_o,
  output logic         p1_stall_o,
  output logic [31:0]  mem_addr_o,
  output logic [255:0] mem_data_o,
  output logic         mem_enable_o,
  output logic         mem_write_o,
  input  logic [255:0] mem_data_i,
  input  logic         mem_ack_i,
  output logic [31:0]  hit_count_o,
  output logic [31:0]  miss_count_o
);
  localparam int LINES = 2 ** INDEX_W;
  localparam int TAG_W = 27 - INDEX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE, FILL} state_t;

  state_t             state;
  logic [LINES-1:0]   valid;
  logic [LINES-1:0]   dirty;
  logic [TAG_W-1:0]   tag_mem [LINES];
  logic [255:0]       data_mem [LINES];
  logic [255:0]       fill_line;

  logic [INDEX_W-1:0] idx;
  logic [TAG_W-1:0]   tag;
  logic [2:0]         off;
  logic [1:0]         unused_addr_bits;
  logic [255:0]       line;
  logic [31:0]        req_line_addr;
  logic               req;
  logic               hit;
  logic               in_idle;
  logic               miss;
  logic               write_hit;

  assign idx              = p1_addr_i[INDEX_W+4:5];
  assign tag              = p1_addr_i[31:INDEX_W+5];
  assign off              = p1_addr_i[4:2];
  assign unused_addr_bits = p1_addr_i[1:0];
  assign line             = data_mem[idx];
  assign req_line_addr    = {tag, idx, 5'b0};

  assign req       = p1_MemRead_i | p1_MemWrite_i;
  assign hit       = req & valid[idx] & (tag_mem[idx] == tag);
  assign in_idle   = (state == IDLE);
  assign miss      = in_idle & req & ~hit;
  assign write_hit = in_idle & p1_MemWrite_i & hit;

  // Gated by reset so the pipeline is released the instant reset asserts.
  assign p1_stall_o = rst_i & (miss | ~in_idle);
  assign p1_data_o  = (in_idle & p1_MemRead_i & ~p1_MemWrite_i & hit) ? line[{off, 5'b0} +: 32] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state        <= IDLE;
      valid        <= '0;
      dirty        <= '0;
      fill_line    <= '0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (write_hit) dirty[idx] <= 1'b1;
          if (miss) begin
            mem_enable_o <= 1'b1;
            if (valid[idx] & dirty[idx]) begin
              state       <= WRITEBACK;
              mem_write_o <= 1'b1;
              mem_addr_o  <= {tag_mem[idx], idx, 5'b0};
              mem_data_o  <= line;
            end else begin
              state       <= ALLOCATE;
              mem_write_o <= 1'b0;
              mem_addr_o  <= req_line_addr;
            end
          end
        end
        WRITEBACK: if (mem_ack_i) begin
          state       <= ALLOCATE;
          mem_write_o <= 1'b0;
          mem_addr_o  <= req_line_addr;
          mem_data_o  <= '0;
        end
        ALLOCATE: if (mem_ack_i) begin
          state        <= FILL;
          fill_line    <= mem_data_i;
          mem_enable_o <= 1'b0;
          mem_addr_o   <= '0;
        end
        FILL: begin
          state      <= IDLE;
          valid[idx] <= 1'b1;
          dirty[idx] <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Line storage carries no reset; the valid bits alone define cache contents.
  always_ff @(posedge clk_i) begin
    if (state == FILL) begin
      data_mem[idx] <= fill_line;
      tag_mem[idx]  <= tag;
    end else if (write_hit) begin
      data_mem[idx][{off, 5'b0} +: 32] <= p1_data_i;
    end
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count;
  logic [31:0] miss_count;
  logic        replay;

  // The first IDLE cycle after FILL is the replayed miss, not a fresh hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      hit_count  <= '0;
      miss_count <= '0;
      replay     <= 1'b0;
    end else begin
      replay <= (state == FILL);
      if (in_idle & hit & ~replay) hit_count <= hit_count + 32'd1;
      if (miss) miss_count <= miss_count + 32'd1;
    end
  end

  assign hit_count_o  = hit_count;
  assign miss_count_o = miss_count;
`else
  assign hit_count_o  = '0;
  assign miss_count_o = '0;
`endif

endmodule
